// File: rtl/elevator_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl_fsm_if
// Description : Request-summary / car-status bundle for the elevator
//               car-motion controller.
//               ctrl_button_up/down/in [2:0] : [0] at current floor,
//                                              [1] above, [2] below
//               position [1:0]               : current floor (00 = 1st)
//               open                         : door open
//               dir_up                       : 1 = up, 0 = down
//               moving                       : car between floors
//               master = request side (drives buttons, watches the car)
//               slave  = controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_ctrl_fsm_if;
    logic [2:0] ctrl_button_up;
    logic [2:0] ctrl_button_down;
    logic [2:0] ctrl_button_in;
    logic [1:0] position;
    logic       open;
    logic       dir_up;
    logic       moving;

    modport master (
        output ctrl_button_up, ctrl_button_down, ctrl_button_in,
        input  position, open, dir_up, moving
    );

    modport slave (
        input  ctrl_button_up, ctrl_button_down, ctrl_button_in,
        output position, open, dir_up, moving
    );
endinterface
`default_nettype wire

// File: rtl/elevator_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl_fsm
// Description : SCAN car-motion controller for a 4-floor elevator. Consumes
//               position-relative request summaries and drives the car
//               position, direction, moving flag and door-open signal.
//               clk   : system clock, rising edge
//               reset : synchronous, active-high
//               bus   : elevator_ctrl_fsm_if.slave (requests in, status out)
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl_fsm #(
    parameter int MOVE_CYCLES = 4,   // cycles to travel one floor (1..255)
    parameter int OPEN_CYCLES = 3    // cycles the door stays open (1..255)
) (
    input  wire                      clk,
    input  wire                      reset,
    elevator_ctrl_fsm_if.slave       bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_move   = 2'd1;
    localparam logic [1:0] c_st_arrive = 2'd2;
    localparam logic [1:0] c_st_open   = 2'd3;

    localparam logic [1:0] c_top_floor = 2'd3;
    localparam logic [1:0] c_bot_floor = 2'd0;

    // Timers count down to zero, so the load value is one less than the
    // number of cycles the state must last.
    localparam logic [7:0] c_move_load = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] c_open_load = 8'(OPEN_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_timer;
    logic [1:0] r_position;
    logic       r_open;
    logic       r_dir_up;
    logic       r_moving;

    logic w_here;
    logic w_above;
    logic w_below;
    logic w_ahead;
    logic w_behind;
    logic w_stop;

    assign w_here = bus.ctrl_button_up[0] | bus.ctrl_button_down[0] | bus.ctrl_button_in[0];

    // Requests pointing through a wall are inconsistent; masking them here
    // keeps every decision below from ever heading toward the wall.
    assign w_above = (bus.ctrl_button_up[1] | bus.ctrl_button_down[1] | bus.ctrl_button_in[1])
                     & (r_position != c_top_floor);
    assign w_below = (bus.ctrl_button_up[2] | bus.ctrl_button_down[2] | bus.ctrl_button_in[2])
                     & (r_position != c_bot_floor);

    assign w_ahead  = r_dir_up ? w_above : w_below;
    assign w_behind = r_dir_up ? w_below : w_above;

    // Stop for car calls, hall calls matching the travel direction, and any
    // hall call here when nothing lies further ahead (end of the sweep).
    assign w_stop = bus.ctrl_button_in[0]
                  | (r_dir_up ? bus.ctrl_button_up[0] : bus.ctrl_button_down[0])
                  | (w_here & ~w_ahead);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_timer    <= 8'd0;
            r_position <= 2'd0;
            r_open     <= 1'b0;
            r_dir_up   <= 1'b1;
            r_moving   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_here) begin
                        r_state <= c_st_open;
                        r_open  <= 1'b1;
                        r_timer <= c_open_load;
                    end else if (w_above & (r_dir_up | ~w_below)) begin
                        r_state  <= c_st_move;
                        r_moving <= 1'b1;
                        r_dir_up <= 1'b1;
                        r_timer  <= c_move_load;
                    end else if (w_below) begin
                        r_state  <= c_st_move;
                        r_moving <= 1'b1;
                        r_dir_up <= 1'b0;
                        r_timer  <= c_move_load;
                    end
                end

                c_st_move: begin
                    if (r_timer == 8'd0) begin
                        r_state  <= c_st_arrive;
                        r_moving <= 1'b0;
                        // Wall guard: a move is never started toward a wall,
                        // but the position update refuses to wrap regardless.
                        if (r_dir_up && (r_position != c_top_floor)) begin
                            r_position <= r_position + 2'd1;
                        end else if (!r_dir_up && (r_position != c_bot_floor)) begin
                            r_position <= r_position - 2'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                c_st_arrive: begin
                    if (w_stop) begin
                        r_state <= c_st_open;
                        r_open  <= 1'b1;
                        r_timer <= c_open_load;
                    end else if (w_ahead) begin
                        r_state  <= c_st_move;
                        r_moving <= 1'b1;
                        r_timer  <= c_move_load;
                    end else if (w_behind) begin
                        r_state  <= c_st_move;
                        r_moving <= 1'b1;
                        r_dir_up <= ~r_dir_up;
                        r_timer  <= c_move_load;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end

                c_st_open: begin
                    // Fixed dwell: new presses do not extend the door time.
                    if (r_timer == 8'd0) begin
                        r_state <= c_st_idle;
                        r_open  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end

                default: begin
                    r_state  <= c_st_idle;
                    r_open   <= 1'b0;
                    r_moving <= 1'b0;
                    r_timer  <= 8'd0;
                end
            endcase
        end
    end

    assign bus.position = r_position;
    assign bus.open     = r_open;
    assign bus.dir_up   = r_dir_up;
    assign bus.moving   = r_moving;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_ctrl_fsm
// Description : Testbench for elevator_ctrl_fsm. Models the per-floor request
//               latches (held until the door opens at that floor) and their
//               position-relative encoding. Expected car events (move start,
//               position change, door open, door close) are queued with their
//               cycle numbers; a monitor pops and compares them as the car
//               produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_ctrl_fsm;

    localparam int MOVE_CYCLES = 4;
    localparam int OPEN_CYCLES = 3;

    localparam logic [1:0] c_ev_move  = 2'd0;
    localparam logic [1:0] c_ev_pos   = 2'd1;
    localparam logic [1:0] c_ev_open  = 2'd2;
    localparam logic [1:0] c_ev_close = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  pos;
        logic        dir;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    elevator_ctrl_fsm_if bus();

    elevator_ctrl_fsm #(
        .MOVE_CYCLES(MOVE_CYCLES),
        .OPEN_CYCLES(OPEN_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    ev_t  sbq[$];
    logic exp_dir = 1'b1;

    logic [3:0] req_up = '0, req_dn = '0, req_in = '0;
    logic [2:0] f_up = '0, f_dn = '0, f_in = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] enc(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] v;
        v = 3'b000;
        for (int f = 0; f < 4; f++) begin
            if (r[f]) begin
                if (f == int'(p))      v[0] = 1'b1;
                else if (f > int'(p))  v[1] = 1'b1;
                else                   v[2] = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        bus.ctrl_button_up   = enc(req_up, bus.position) | f_up;
        bus.ctrl_button_down = enc(req_dn, bus.position) | f_dn;
        bus.ctrl_button_in   = enc(req_in, bus.position) | f_in;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    bit         mon_en = 1'b0;
    logic [1:0] prev_pos = 2'd0;
    logic       prev_open = 1'b0;
    logic       prev_mov = 1'b0;

    task automatic got(input logic [1:0] kind);
        ev_t a, e;
        a.kind = kind;
        a.pos  = bus.position;
        a.dir  = bus.dir_up;
        a.cyc  = cyc;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d pos=%0d dir=%0d cyc=%0d want none",
                     a.kind, a.pos, a.dir, a.cyc);
        end else begin
            e = sbq.pop_front();
            if (a != e) begin
                bad++;
                $display("FAIL car_event: got kind=%0d pos=%0d dir=%0d cyc=%0d want kind=%0d pos=%0d dir=%0d cyc=%0d",
                         a.kind, a.pos, a.dir, a.cyc, e.kind, e.pos, e.dir, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.moving && !prev_mov)       got(c_ev_move);
            if (bus.position != prev_pos)      got(c_ev_pos);
            if (bus.open && !prev_open)        got(c_ev_open);
            if (!bus.open && prev_open)        got(c_ev_close);
        end
        prev_pos  = bus.position;
        prev_open = bus.open;
        prev_mov  = bus.moving;
    end

    // ---------------- stimulus helpers ----------------
    // One step of time; the request latches drop a floor's calls while the
    // door is open there.
    task automatic tick();
        @(negedge clk);
        if (bus.open) begin
            req_up[bus.position] = 1'b0;
            req_dn[bus.position] = 1'b0;
            req_in[bus.position] = 1'b0;
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push(input logic [1:0] kind, input int pos, input logic dir, input int c);
        ev_t e;
        e.kind = kind;
        e.pos  = 2'(pos);
        e.dir  = dir;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Straight trip from 'from' to 'to' with no intermediate stop, ending with
    // a full door cycle. IDLE/ARRIVE decision is in cycle c0; e returns the
    // cycle in which the door closes (car IDLE again).
    task automatic travel(input int from, input int to, input int c0, output int e);
        int n, step, m;
        if (to > from)      exp_dir = 1'b1;
        else if (to < from) exp_dir = 1'b0;
        n    = (to > from) ? (to - from) : (from - to);
        step = (to > from) ? 1 : -1;
        for (int k = 0; k < n; k++) begin
            m = c0 + 1 + k * (MOVE_CYCLES + 1);
            push(c_ev_move, from + k * step, exp_dir, m);
            push(c_ev_pos, from + (k + 1) * step, exp_dir, m + MOVE_CYCLES);
        end
        m = c0 + n * (MOVE_CYCLES + 1) + 1;
        push(c_ev_open, to, exp_dir, m);
        push(c_ev_close, to, exp_dir, m + OPEN_CYCLES);
        e = m + OPEN_CYCLES;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0, e, e2;

        // 1. reset values
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_position", int'(bus.position), 0);
        chk("rst_open",     int'(bus.open),     0);
        chk("rst_dir_up",   int'(bus.dir_up),   1);
        chk("rst_moving",   int'(bus.moving),   0);
        mon_en = 1'b1;

        // 1b. reset in MOVE cycle 2 returns to floor 00, idle
        tick();
        c0 = cyc;
        req_in[3] = 1'b1;
        push(c_ev_move, 0, 1'b1, c0 + 1);
        wait_until(c0 + 2);
        chk("move_cycle2_moving", int'(bus.moving), 1);
        reset = 1'b1;
        req_in = '0;
        tick();
        chk("midmove_rst_position", int'(bus.position), 0);
        chk("midmove_rst_moving",   int'(bus.moving),   0);
        chk("midmove_rst_open",     int'(bus.open),     0);
        chk("midmove_rst_dir_up",   int'(bus.dir_up),   1);
        reset = 1'b0;
        exp_dir = 1'b1;
        tick();

        // 2. car call at the current floor
        c0 = cyc;
        req_in[0] = 1'b1;
        travel(0, 0, c0, e);
        wait_until(e + 2);
        chk("same_floor_idle_open",   int'(bus.open),   0);
        chk("same_floor_idle_moving", int'(bus.moving), 0);

        // 3. 00 -> 11 without intermediate stops
        c0 = cyc;
        req_in[3] = 1'b1;
        travel(0, 3, c0, e);
        wait_until(e + 1);

        // 6. idle at the top with no requests, then an impossible 'above'
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_top_position", int'(bus.position), 3);
            chk("idle_top_open",     int'(bus.open),     0);
            chk("idle_top_moving",   int'(bus.moving),   0);
        end
        f_up = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wall_top_position", int'(bus.position), 3);
            chk("wall_top_moving",   int'(bus.moving),   0);
            chk("wall_top_dir_up",   int'(bus.dir_up),   1);
        end
        f_up = 3'b000;
        tick();

        // bring the car to 01 heading up
        c0 = cyc;
        req_in[0] = 1'b1;
        travel(3, 0, c0, e);
        wait_until(e + 1);
        c0 = cyc;
        req_in[1] = 1'b1;
        travel(0, 1, c0, e);
        wait_until(e + 1);

        // 4. at 01 heading up, calls for 10 and 00: up first, then reverse
        c0 = cyc;
        req_in[2] = 1'b1;
        req_in[0] = 1'b1;
        travel(1, 2, c0, e);
        travel(2, 0, e, e2);
        wait_until(e2 + 1);

        // impossible 'below' at the bottom floor
        f_dn = 3'b100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wall_bot_position", int'(bus.position), 0);
            chk("wall_bot_moving",   int'(bus.moving),   0);
            chk("wall_bot_dir_up",   int'(bus.dir_up),   0);
        end
        f_dn = 3'b000;
        tick();

        // 5. heading up to 11, hall-down at 10 is passed, served on return
        c0 = cyc;
        req_in[3] = 1'b1;
        travel(0, 3, c0, e);
        wait_until(c0 + 3);
        req_dn[2] = 1'b1;
        travel(3, 2, e, e2);
        wait_until(e2 + 2);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
